pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013: instruction word used for a bubble (addi x0,x0,0).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port pc_pause, input, 1: hold the fetch PC.
REQ-006 SHALL have port pipe_pause, input, 4: per-stage hold; bit3=ID, bit2=EX, bit1=MEM, bit0=WB.
REQ-007 SHALL have port pipe_bubble, input, 4: per-stage NOP insert; same bit mapping as pipe_pause.
REQ-008 SHALL have port redirect, input, 1: taken branch or jump this cycle.
REQ-009 SHALL have port redirect_pc, input, 32: target PC for redirect.
REQ-010 SHALL have port if_instr, input, 32: instruction fetched at if_pc.
REQ-011 SHALL have port if_pc, output, 32: current fetch PC.
REQ-012 SHALL have ports {id,ex,mem,wb}_pc, output, 32 each: PC held in each stage register.
REQ-013 SHALL have ports {id,ex,mem,wb}_instr, output, 32 each: instruction held in each stage register.
REQ-014 SHALL have ports {id,ex,mem,wb}_valid, output, 1 each: stage holds a real, non-bubble instruction.

Function
REQ-015 SHALL update if_pc with priority: redirect -> redirect_pc; else pc_pause -> hold; else if_pc+4, wrapping modulo 2^32.
REQ-016 SHALL give each stage register (ID, EX, MEM, WB) per-cycle priority: bubble bit -> {pc=0, instr=NOP_INSTR, valid=0}; else pause bit -> hold all fields; else load from the upstream stage.
REQ-017 SHALL use upstream sources: ID from {if_pc, if_instr, valid=1}; EX from ID; MEM from EX; WB from MEM.
REQ-018 SHALL treat simultaneous pause and bubble on the same stage as bubble.
REQ-019 SHALL load each stage one cycle after its upstream stage; latency IF->WB is exactly 4 cycles with no pause or bubble.
REQ-020 SHALL, when a stage is paused and the next stage is not, load the downstream stage from the paused stage's current contents. The hazard unit pairs such a pause with a downstream bubble, so duplication does not occur in practice.
REQ-021 SHALL apply redirect and a same-cycle ID bubble independently; the next ID holds NOP_INSTR and if_pc equals redirect_pc.
REQ-022 SHALL keep all outputs as direct register outputs, with no combinational path from inputs to outputs.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, set if_pc=RESET_PC, all stage pc=0, instr=NOP_INSTR, valid=0, overriding every other input.
REQ-024 SHALL, on reset mid-operation, discard all in-flight stages; the first valid ID appears 1 cycle after rst deasserts, with id_pc=RESET_PC.

Configuration
REQ-025 SHALL, with macro PIPE_STATS_EN defined, add outputs stall_cnt[31:0] and bubble_cnt[31:0].
REQ-026 SHALL increment stall_cnt on each cycle with pc_pause=1, and bubble_cnt on each cycle with wb_valid=0 after reset.
REQ-027 SHALL clear both counters on rst and let them wrap at 2^32.
REQ-028 SHALL, without PIPE_STATS_EN, omit both ports and all counter logic.

Structure
REQ-029 SHALL place stage bit indices (STAGE_ID=3, STAGE_EX=2, STAGE_MEM=1, STAGE_WB=0), NOP_INSTR and RESET_PC defaults in shared package riscv_pkg.
REQ-030 SHALL implement each stage with one sub-module, pipe_reg (pc/instr/valid with pause/bubble inputs), instantiated four times.

Verification
REQ-031 SHALL cover free run: after reset with no pause, bubble or redirect, if_pc steps 0,4,8,...; wb_pc=0 with wb_valid=1 at cycle 4 after reset release.
REQ-032 SHALL cover load-use: pc_pause=1, pipe_pause=4'b1000, pipe_bubble=4'b0100 for 1 cycle -> if_pc and ID hold, ex_valid=0 with ex_instr=32'h13, MEM receives the old EX.
REQ-033 SHALL cover branch: redirect=1, redirect_pc=32'h100, pipe_bubble=4'b1100 -> next cycle if_pc=32'h100, id_valid=0, ex_valid=0.
REQ-034 SHALL cover MEM flush: pipe_bubble=4'b1110, pc_pause=1 -> ID, EX and MEM are NOP with valid=0, WB loads the old MEM, if_pc holds.
REQ-035 SHALL cover wrap and reset: if_pc=32'hFFFF_FFFC advances to 0; rst asserted mid-stream -> all valid=0 next cycle; with PIPE_STATS_EN, 3 pc_pause cycles give stall_cnt=3.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the in-order pipeline control slice: stage bit
// positions in the pause/bubble vectors and the reset/NOP defaults.
package riscv_pkg;

  localparam int unsigned STAGE_ID  = 3;
  localparam int unsigned STAGE_EX  = 2;
  localparam int unsigned STAGE_MEM = 1;
  localparam int unsigned STAGE_WB  = 0;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/pipe_reg.sv
// One pipeline stage register (pc/instr/valid). Bubble beats pause; pause
// holds; otherwise the stage loads from its upstream source.
module pipe_reg
  import riscv_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        bubble,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        in_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_valid
);

  logic [31:0] pc_d, pc_q;
  logic [31:0] instr_d, instr_q;
  logic        valid_d, valid_q;

  always_comb begin
    pc_d    = in_pc;
    instr_d = in_instr;
    valid_d = in_valid;
    if (bubble) begin
      pc_d    = 32'h0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (pause) begin
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Fetch PC and ID/EX/MEM/WB stage registers driven by hazard-unit pause,
// bubble and redirect. Optional counters under macro PIPE_STATS_EN.
module pipe_ctrl
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_pause,
  input  logic [3:0]  pipe_pause,
  input  logic [3:0]  pipe_bubble,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] id_pc,
  output logic [31:0] ex_pc,
  output logic [31:0] mem_pc,
  output logic [31:0] wb_pc,
  output logic [31:0] id_instr,
  output logic [31:0] ex_instr,
  output logic [31:0] mem_instr,
  output logic [31:0] wb_instr,
  output logic        id_valid,
  output logic        ex_valid,
  output logic        mem_valid,
  output logic        wb_valid
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
`endif
);

  logic [31:0] if_pc_d, if_pc_q;

  always_comb begin
    if_pc_d = if_pc_q + 32'd4;
    if (redirect)      if_pc_d = redirect_pc;
    else if (pc_pause) if_pc_d = if_pc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) if_pc_q <= RESET_PC;
    else     if_pc_q <= if_pc_d;
  end

  assign if_pc = if_pc_q;

  pipe_reg #(.NOP_INSTR(NOP_INSTR)) u_id (
    .clk(clk), .rst(rst),
    .pause(pipe_pause[STAGE_ID]), .bubble(pipe_bubble[STAGE_ID]),
    .in_pc(if_pc_q), .in_instr(if_instr), .in_valid(1'b1),
    .out_pc(id_pc), .out_instr(id_instr), .out_valid(id_valid)
  );

  pipe_reg #(.NOP_INSTR(NOP_INSTR)) u_ex (
    .clk(clk), .rst(rst),
    .pause(pipe_pause[STAGE_EX]), .bubble(pipe_bubble[STAGE_EX]),
    .in_pc(id_pc), .in_instr(id_instr), .in_valid(id_valid),
    .out_pc(ex_pc), .out_instr(ex_instr), .out_valid(ex_valid)
  );

  pipe_reg #(.NOP_INSTR(NOP_INSTR)) u_mem (
    .clk(clk), .rst(rst),
    .pause(pipe_pause[STAGE_MEM]), .bubble(pipe_bubble[STAGE_MEM]),
    .in_pc(ex_pc), .in_instr(ex_instr), .in_valid(ex_valid),
    .out_pc(mem_pc), .out_instr(mem_instr), .out_valid(mem_valid)
  );

  pipe_reg #(.NOP_INSTR(NOP_INSTR)) u_wb (
    .clk(clk), .rst(rst),
    .pause(pipe_pause[STAGE_WB]), .bubble(pipe_bubble[STAGE_WB]),
    .in_pc(mem_pc), .in_instr(mem_instr), .in_valid(mem_valid),
    .out_pc(wb_pc), .out_instr(wb_instr), .out_valid(wb_valid)
  );

`ifdef PIPE_STATS_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;
  logic [31:0] bubble_cnt_d, bubble_cnt_q;

  // bubble_cnt samples the registered wb_valid, i.e. the WB slot of this cycle
  always_comb begin
    stall_cnt_d  = stall_cnt_q + {31'd0, pc_pause};
    bubble_cnt_d = bubble_cnt_q + {31'd0, ~wb_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic,
// compared against a stage-array reference model.
module tb_pipe_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_pause;
  logic [3:0]  pipe_pause;
  logic [3:0]  pipe_bubble;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] id_pc, ex_pc, mem_pc, wb_pc;
  logic [31:0] id_instr, ex_instr, mem_instr, wb_instr;
  logic        id_valid, ex_valid, mem_valid, wb_valid;
`ifdef PIPE_STATS_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .pc_pause(pc_pause), .pipe_pause(pipe_pause),
    .pipe_bubble(pipe_bubble), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_instr(if_instr), .if_pc(if_pc),
    .id_pc(id_pc), .ex_pc(ex_pc), .mem_pc(mem_pc), .wb_pc(wb_pc),
    .id_instr(id_instr), .ex_instr(ex_instr), .mem_instr(mem_instr), .wb_instr(wb_instr),
    .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid)
`ifdef PIPE_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  // Reference model: slot 0=ID, 1=EX, 2=MEM, 3=WB
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } slot_t;

  slot_t       m_st[4];
  logic [31:0] m_pc;
  logic [31:0] m_stall, m_bub;
  int          checks = 0;
  int          errors = 0;

  task automatic model_step();
    slot_t nxt[4];
    slot_t src;
    int    b;
    for (int k = 0; k < 4; k++) begin
      b = 3 - k;
      if (k == 0) begin
        src.pc = m_pc; src.instr = if_instr; src.valid = 1'b1;
      end else begin
        src = m_st[k-1];
      end
      if (pipe_bubble[b]) begin
        nxt[k].pc = 32'h0; nxt[k].instr = NOP; nxt[k].valid = 1'b0;
      end else if (pipe_pause[b]) begin
        nxt[k] = m_st[k];
      end else begin
        nxt[k] = src;
      end
    end
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        nxt[k].pc = 32'h0; nxt[k].instr = NOP; nxt[k].valid = 1'b0;
      end
      m_pc = 32'h0; m_stall = 0; m_bub = 0;
    end else begin
      if (!m_st[3].valid) m_bub = m_bub + 1;
      if (pc_pause) m_stall = m_stall + 1;
      if (redirect) m_pc = redirect_pc;
      else if (!pc_pause) m_pc = m_pc + 32'd4;
    end
    for (int k = 0; k < 4; k++) m_st[k] = nxt[k];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".if_pc"},     if_pc,              m_pc);
    chk({tag, ".id_pc"},     id_pc,              m_st[0].pc);
    chk({tag, ".id_instr"},  id_instr,           m_st[0].instr);
    chk({tag, ".id_valid"},  {31'd0, id_valid},  {31'd0, m_st[0].valid});
    chk({tag, ".ex_pc"},     ex_pc,              m_st[1].pc);
    chk({tag, ".ex_instr"},  ex_instr,           m_st[1].instr);
    chk({tag, ".ex_valid"},  {31'd0, ex_valid},  {31'd0, m_st[1].valid});
    chk({tag, ".mem_pc"},    mem_pc,             m_st[2].pc);
    chk({tag, ".mem_instr"}, mem_instr,          m_st[2].instr);
    chk({tag, ".mem_valid"}, {31'd0, mem_valid}, {31'd0, m_st[2].valid});
    chk({tag, ".wb_pc"},     wb_pc,              m_st[3].pc);
    chk({tag, ".wb_instr"},  wb_instr,           m_st[3].instr);
    chk({tag, ".wb_valid"},  {31'd0, wb_valid},  {31'd0, m_st[3].valid});
`ifdef PIPE_STATS_EN
    chk({tag, ".stall_cnt"},  stall_cnt,  m_stall);
    chk({tag, ".bubble_cnt"}, bubble_cnt, m_bub);
`endif
  endtask

  // One clock: inputs are stable across the edge, outputs sampled 1 ns later
  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    rst = 1'b0; pc_pause = 1'b0; pipe_pause = 4'b0; pipe_bubble = 4'b0;
    redirect = 1'b0; redirect_pc = 32'h0; if_instr = $urandom;
  endtask

  logic [31:0] old_ex_pc, old_mem_pc, old_id_pc, old_if_pc;

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_st[k].pc = 32'h0; m_st[k].instr = NOP; m_st[k].valid = 1'b0;
    end
    m_pc = 32'h0; m_stall = 0; m_bub = 0;
    idle();
    rst = 1'b1;
    #1;
    tick("reset0");
    tick("reset1");

    // Free run: wb_pc=0 valid at cycle 4 after release
    idle();
    for (int c = 1; c <= 6; c++) begin
      tick("free");
      if (c == 4) begin
        chk("free.wb_pc_c4", wb_pc, 32'h0);
        chk("free.wb_valid_c4", {31'd0, wb_valid}, 32'd1);
      end
      if_instr = $urandom;
    end

    // Load-use
    pc_pause = 1'b1; pipe_pause = 4'b1000; pipe_bubble = 4'b0100;
    old_id_pc = id_pc; old_ex_pc = ex_pc; old_if_pc = if_pc;
    tick("loaduse");
    chk("loaduse.if_hold", if_pc, old_if_pc);
    chk("loaduse.id_hold", id_pc, old_id_pc);
    chk("loaduse.ex_instr", ex_instr, 32'h13);
    chk("loaduse.mem_old_ex", mem_pc, old_ex_pc);
    idle();
    tick("after_loaduse");

    // Branch
    redirect = 1'b1; redirect_pc = 32'h100; pipe_bubble = 4'b1100;
    tick("branch");
    chk("branch.if_pc", if_pc, 32'h100);
    chk("branch.id_valid", {31'd0, id_valid}, 32'd0);
    idle();
    tick("after_branch");

    // MEM flush
    pc_pause = 1'b1; pipe_bubble = 4'b1110;
    old_mem_pc = mem_pc; old_if_pc = if_pc;
    tick("memflush");
    chk("memflush.wb_old_mem", wb_pc, old_mem_pc);
    chk("memflush.if_hold", if_pc, old_if_pc);
    chk("memflush.mem_instr", mem_instr, 32'h13);
    idle();

    // Wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick("wrap_set");
    idle();
    tick("wrap");
    chk("wrap.if_pc_zero", if_pc, 32'h0);
    for (int c = 0; c < 3; c++) begin
      if_instr = $urandom;
      tick("wrap_run");
    end

    // Mid-stream reset, then first valid ID one cycle after release
    rst = 1'b1;
    tick("midreset");
    chk("midreset.wb_valid", {31'd0, wb_valid}, 32'd0);
    idle();
    tick("post_reset");
    chk("post_reset.id_valid", {31'd0, id_valid}, 32'd1);
    chk("post_reset.id_pc", id_pc, 32'h0);

    // Three stall cycles
    pc_pause = 1'b1;
    for (int c = 0; c < 3; c++) tick("stall3");
`ifdef PIPE_STATS_EN
    chk("stall3.stall_cnt", stall_cnt, 32'd3);
`endif
    idle();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 99) == 0);
      pc_pause    = ($urandom_range(0, 3) == 0);
      pipe_pause  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      pipe_bubble = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      redirect    = ($urandom_range(0, 7) == 0);
      redirect_pc = {$urandom} & 32'hFFFF_FFFC;
      if_instr    = $urandom;
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
